// File: rtl/cdb_result_file.sv
// cdb_result_file: per-ROB-tag result slots fed by the ALU lanes and the load unit.
// It drives the CDB data array and the calculated/branch bit vectors that the
// reservation stations snoop. ROB allocation, commit and flush clear slot state.
module cdb_result_file #(
  parameter int NUM_SRC   = 5,
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         wr_valid,
  input  logic [NUM_SRC*TAG_W-1:0]   wr_tag,
  input  logic [NUM_SRC*32-1:0]      wr_data,
  input  logic [NUM_SRC*32-1:0]      wr_alt,
  input  logic [NUM_SRC-1:0]         wr_ld_pc,
  input  logic [NUM_SRC-1:0]         wr_update_br,
  input  logic                       alloc_valid,
  input  logic [TAG_W-1:0]           alloc_tag,
  input  logic                       commit_valid,
  input  logic [TAG_W-1:0]           commit_tag,
  input  logic                       flush,
  output logic [ROB_DEPTH*32-1:0]    cdb_data,
  output logic [ROB_DEPTH-1:0]       robs_calculated,
  output logic [ROB_DEPTH-1:0]       br_valid,
  output logic [ROB_DEPTH-1:0]       br_taken,
  output logic [ROB_DEPTH-1:0]       allocated,
  output logic                       collision_err
);

  // Slot state
  logic [ROB_DEPTH-1:0][31:0] data_q, data_d;
  logic [ROB_DEPTH-1:0]       calc_q, calc_d;
  logic [ROB_DEPTH-1:0]       brv_q, brv_d;
  logic [ROB_DEPTH-1:0]       brt_q, brt_d;
  logic [ROB_DEPTH-1:0]       alloc_q, alloc_d;
  logic                       coll_q, coll_d;

  // Per-source unpacking
  logic [NUM_SRC-1:0][TAG_W-1:0] src_tag;
  logic [NUM_SRC-1:0][31:0]      src_val;
  logic [NUM_SRC-1:0]            src_taken;

  // Per-slot winning write
  logic [ROB_DEPTH-1:0]          hit;
  logic [ROB_DEPTH-1:0][31:0]    win_val;
  logic [ROB_DEPTH-1:0]          win_br;
  logic [ROB_DEPTH-1:0]          win_taken;
  logic                          coll_now;

  // Split the flat source buses and pick the pc-derived value where requested
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_tag[i]   = wr_tag[i*TAG_W +: TAG_W];
      src_val[i]   = wr_ld_pc[i] ? wr_alt[i*32 +: 32] : wr_data[i*32 +: 32];
      src_taken[i] = wr_data[i*32];
    end
  end

  // Per slot, the lowest-indexed valid source wins; a second hit flags a collision
  always_comb begin
    coll_now  = 1'b0;
    hit       = '0;
    win_val   = '0;
    win_br    = '0;
    win_taken = '0;
    for (int s = 0; s < ROB_DEPTH; s++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (wr_valid[i] && (src_tag[i] == TAG_W'(s))) begin
          if (hit[s]) begin
            coll_now = 1'b1;
          end else begin
            hit[s]       = 1'b1;
            win_val[s]   = src_val[i];
            win_br[s]    = wr_update_br[i];
            win_taken[s] = src_taken[i];
          end
        end
      end
    end
  end

  // Slot next state: flush > alloc > commit > write (reset handled in the register)
  always_comb begin
    data_d  = data_q;
    calc_d  = calc_q;
    brv_d   = brv_q;
    brt_d   = brt_q;
    alloc_d = alloc_q;
    coll_d  = coll_q | coll_now;
    for (int s = 0; s < ROB_DEPTH; s++) begin
      if (flush) begin
        // br_taken and data are kept; only the validity bits are dropped
        alloc_d[s] = 1'b0;
        calc_d[s]  = 1'b0;
        brv_d[s]   = 1'b0;
      end else if (alloc_valid && (alloc_tag == TAG_W'(s))) begin
        // Re-allocation of a live slot simply re-clears it (ROB wrap case)
        alloc_d[s] = 1'b1;
        calc_d[s]  = 1'b0;
        brv_d[s]   = 1'b0;
        brt_d[s]   = 1'b0;
      end else if (commit_valid && (commit_tag == TAG_W'(s))) begin
        alloc_d[s] = 1'b0;
        calc_d[s]  = 1'b0;
        brv_d[s]   = 1'b0;
      end else if (hit[s] && alloc_q[s]) begin
        // Writes to unallocated slots are dropped silently
        data_d[s] = win_val[s];
        calc_d[s] = 1'b1;
        if (win_br[s]) begin
          brv_d[s] = 1'b1;
          brt_d[s] = win_taken[s];
        end
      end
    end
  end

  // State registers with synchronous reset over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      calc_q  <= '0;
      brv_q   <= '0;
      brt_q   <= '0;
      alloc_q <= '0;
      coll_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      calc_q  <= calc_d;
      brv_q   <= brv_d;
      brt_q   <= brt_d;
      alloc_q <= alloc_d;
      coll_q  <= coll_d;
    end
  end

  assign cdb_data        = data_q;
  assign robs_calculated = calc_q;
  assign br_valid        = brv_q;
  assign br_taken        = brt_q;
  assign allocated       = alloc_q;
  assign collision_err   = coll_q;

endmodule

// File: doc/cdb_result_file.md
# cdb_result_file

Registered common-data-bus result file that sits directly downstream of the reservation stations and their ALUs, plus the load unit. It captures every completed result into a per-ROB-tag slot and drives the `cdb` data array and the `robs_calculated` bit vector that the reservation stations snoop. It also records branch outcomes for the ROB, and clears slots on ROB allocation, commit and flush.

## Interface
Parameters:
- NUM_SRC, 5, number of result producers (4 ALU lanes + 1 load unit); index 0 has highest priority
- ROB_DEPTH, 8, number of ROB entries / CDB slots
- TAG_W, 3, log2(ROB_DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_valid  in  NUM_SRC  per-source result strobe (ALU lanes: reservation station `start_exe`)
- wr_tag  in  NUM_SRC×TAG_W  destination ROB tag
- wr_data  in  NUM_SRC×32  ALU / load result
- wr_alt  in  NUM_SRC×32  pc-derived value (pc+4, AUIPC/LUI result)
- wr_ld_pc  in  NUM_SRC  select wr_alt instead of wr_data (`ld_pc_to_cdb`)
- wr_update_br  in  NUM_SRC  result is a branch compare; bit 0 of wr_data is the taken flag
- alloc_valid, alloc_tag  in  1, TAG_W  ROB allocated an entry this cycle
- commit_valid, commit_tag  in  1, TAG_W  ROB retired its head this cycle
- flush  in  1  pipeline flush
- cdb_data  out  ROB_DEPTH×32  slot data
- robs_calculated  out  ROB_DEPTH  slot holds a valid result
- br_valid  out  ROB_DEPTH  slot holds a resolved branch
- br_taken  out  ROB_DEPTH  resolved branch direction
- allocated  out  ROB_DEPTH  internal allocation bitmap
- collision_err  out  1  sticky: two sources wrote the same tag in one cycle

## Operation
- Reset values: cdb_data all 0, robs_calculated 0, br_valid 0, br_taken 0, allocated 0, collision_err 0.
- Allocation: alloc_valid sets allocated[alloc_tag]. It also clears robs_calculated, br_valid and br_taken for that slot. If the slot is already allocated, it is re-cleared; no error.
- Write: the selected value is `wr_ld_pc ? wr_alt : wr_data`.
  - A write is accepted only if allocated[tag] is 1 and no alloc, commit or flush targets the slot in the same cycle.
  - On acceptance, cdb_data[tag] takes the value and robs_calculated[tag] is set to 1.
  - If wr_update_br is also set, br_valid[tag] is set to 1 and br_taken[tag] takes wr_data[0].
- Write to an unallocated tag: ignored silently.
- Same-tag collision: if several valid sources target one tag, the lowest source index wins and collision_err is set. collision_err clears only on rst.
- Different tags: any number of sources write in the same cycle with no restriction.
- Commit: clears allocated, robs_calculated and br_valid for commit_tag. cdb_data is retained.
- Flush: clears all allocated, robs_calculated and br_valid bits. cdb_data is retained. Flush has priority over alloc, commit and write in the same cycle.
- Priority per slot: rst > flush > alloc > commit > write.
- Alloc and commit on the same tag in one cycle: alloc wins, so the slot ends allocated and clean (ROB wrap with ROB_DEPTH entries in flight).

## Timing
- All outputs are registered. A write at edge N is visible on cdb_data and robs_calculated after edge N. The reservation station CHECK state can capture it in cycle N+1.
- Result latency: 1 cycle from wr_valid to robs_calculated.
- Clear latency (alloc, commit, flush): 1 cycle.
- No backpressure. Every valid, accepted write completes in the cycle it is presented; sources never stall.
- Reset mid-operation: on the next edge, state equals the reset state regardless of other inputs.

## Test plan
- Basic write: after rst, alloc tag 3. Next cycle write src1 tag 3 with wr_data=0x1234, wr_ld_pc=0. Required: cdb_data[3]=0x1234 and robs_calculated[3]=1 one cycle later.
- Pc select and branch: alloc tags 2 and 5. Same cycle:
  - src0 writes tag 2 with ld_pc=1, wr_alt=0x40000008.
  - src2 writes tag 5 with update_br=1, wr_data=1.
  - Required: cdb_data[2]=0x40000008, br_valid[5]=1, br_taken[5]=1.
- Collision: alloc tag 4, then src1 writes 0xAAAA and src3 writes 0xBBBB to tag 4 in the same cycle. Required: cdb_data[4]=0xAAAA and collision_err=1, staying 1 until rst.
- Unallocated and commit race: write tag 6 without prior alloc; required robs_calculated[6]=0. Then alloc 6, and in the next cycle commit 6 and write 6 together; required robs_calculated[6]=0, allocated[6]=0.
- Flush: allocate and write tags 0–7 so all robs_calculated=0xFF. Assert flush together with a write to tag 1. Required: robs_calculated=0x00, allocated=0x00, br_valid=0x00, cdb_data unchanged.
- Wrap and reset: alloc 0 and commit 0 in the same cycle; required allocated[0]=1, robs_calculated[0]=0. Then assert rst with wr_valid high; required all outputs 0 next cycle.
